// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports, the downstream memory port and status.
// slave = arbiter side, master = requesters plus memory (the environment).
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          r0_read;
  logic          r0_write;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic [DW-1:0] r0_rdata;
  logic          r0_resp;

  logic          r1_read;
  logic          r1_write;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic [DW-1:0] r1_rdata;
  logic          r1_resp;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_resp;

  logic          busy;
  logic          owner;
  logic          timeout_err;

  modport slave (
    input  r0_read, r0_write, r0_addr, r0_wdata,
    output r0_rdata, r0_resp,
    input  r1_read, r1_write, r1_addr, r1_wdata,
    output r1_rdata, r1_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp,
    output busy, owner, timeout_err
  );

  modport master (
    output r0_read, r0_write, r0_addr, r0_wdata,
    input  r0_rdata, r0_resp,
    output r1_read, r1_write, r1_addr, r1_wdata,
    input  r1_rdata, r1_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp,
    input  busy, owner, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with one transaction in flight and a per-transaction watchdog.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.

// Per-port completion routing: only the owner ever sees resp/rdata.
module mem_arbiter_port #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          i_own,
  input  logic          i_mem_resp,
  input  logic          i_tmo,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_resp,
  output logic [DW-1:0] o_rdata
);
  assign o_resp = i_own & (i_mem_resp | i_tmo);

  always_comb begin
    o_rdata = '0;
    if (i_own & i_mem_resp)  o_rdata = i_mem_rdata;
    else if (i_own & i_tmo)  o_rdata = ERR_DATA;
  end
endmodule

module mem_arbiter #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 256,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam int NP = 2;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        r_state;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_busy;
  logic          r_owner;
  logic          r_tmo_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [WW-1:0] r_wdog;
`ifdef ARB_RR_EN
  logic          r_last;
`endif

  req_t [NP-1:0]          w_port;
  logic [NP-1:0]          w_req;
  logic [NP-1:0]          w_own;
  logic [NP-1:0]          w_resp;
  logic [NP-1:0][DW-1:0]  w_rdata;
  logic                   w_win;
  logic                   w_tmo;
  logic                   w_done;
  logic                   w_mem_resp;
  logic [DW-1:0]          w_mem_rdata;

  // A simultaneous read+write is carried as a write.
  assign w_port[0] = {bus.r0_write, bus.r0_addr, bus.r0_wdata};
  assign w_port[1] = {bus.r1_write, bus.r1_addr, bus.r1_wdata};
  assign w_req     = {bus.r1_read | bus.r1_write, bus.r0_read | bus.r0_write};

`ifdef ARB_RR_EN
  assign w_win = (&w_req) ? ~r_last : w_req[1];
`else
  assign w_win = w_req[1] & ~w_req[0];
`endif

  assign w_own       = {r_state == GNT1, r_state == GNT0};
  assign w_mem_resp  = bus.mem_resp;
  assign w_mem_rdata = bus.mem_rdata;

  // Expiry fires on the cycle the counter equals TIMEOUT; a real response that cycle wins.
  assign w_tmo  = (TIMEOUT != 0) && r_busy && (r_wdog == WW'(TIMEOUT)) && !bus.mem_resp;
  assign w_done = |w_resp;

  mem_arbiter_port #(.DW(DW), .ERR_DATA(ERR_DATA)) u_port [NP-1:0] (
    .i_own       (w_own),
    .i_mem_resp  (w_mem_resp),
    .i_tmo       (w_tmo),
    .i_mem_rdata (w_mem_rdata),
    .o_resp      (w_resp),
    .o_rdata     (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
      r_owner     <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wdog      <= '0;
`ifdef ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state     <= w_win ? GNT1 : GNT0;
            r_busy      <= 1'b1;
            r_owner     <= w_win;
            r_addr      <= w_port[w_win].addr;
            r_wdata     <= w_port[w_win].wdata;
            r_mem_write <= w_port[w_win].wr;
            r_mem_read  <= ~w_port[w_win].wr;
            r_wdog      <= '0;
`ifdef ARB_RR_EN
            r_last      <= w_win;
`endif
          end
        end
        GNT0, GNT1: begin
          if (w_done) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_tmo) r_tmo_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.r0_resp     = w_resp[0];
  assign bus.r0_rdata    = w_rdata[0];
  assign bus.r1_resp     = w_resp[1];
  assign bus.r1_rdata    = w_rdata[1];
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_wdata   = r_wdata;
  assign bus.busy        = r_busy;
  assign bus.owner       = r_owner;
  assign bus.timeout_err = r_tmo_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected responses, a negedge monitor checks
// grants, downstream bus and responses. Port 0 uses 0x10xx, port 1 0x20xx; addr bit 7 = memory hangs.
module tb_mem_arbiter;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct {
    bit          wr;
    bit          hang;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] dn_mem[logic [31:0]];
  int issue_cyc[2];
  int force_delay = 0;
  bit late_pulse = 0;
  bit chk_lat = 0;
  bit skip_mon = 0;
  int cur_delay = 0;
  bit cur_hang = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int p);
    return (p == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t q_pop(input int p);
    return (p == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic logic [31:0] raddr(input int p, input bit hang);
    logic [31:0] base;
    base = (p == 0) ? 32'h1000 : 32'h2000;
    return base | ($urandom_range(0, 31) << 2) | (hang ? 32'h80 : 32'h0);
  endfunction

  // ---------------- memory model: responds after a chosen delay, never on hang addresses
  int r_cnt = 0;
  bit in_txn = 0;
  always @(posedge clk) begin
    #1;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'h0BAD_0BAD;
    if (!rst_n) in_txn = 0;
    else if (!(bus.mem_read | bus.mem_write)) begin
      in_txn = 0;
      if (late_pulse) begin
        bus.mem_resp = 1'b1;
        late_pulse   = 0;
      end
    end else begin
      if (!in_txn) begin
        in_txn    = 1;
        r_cnt     = 0;
        cur_hang  = bus.mem_addr[7];
        cur_delay = (force_delay > 0) ? force_delay : int'($urandom_range(1, 5));
      end
      r_cnt++;
      if (!cur_hang && r_cnt == cur_delay) begin
        bus.mem_resp = 1'b1;
        if (bus.mem_write) begin
          dn_mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata        = ~bus.mem_wdata;
        end else begin
          bus.mem_rdata = dn_mem.exists(bus.mem_addr) ? dn_mem[bus.mem_addr]
                                                      : (bus.mem_addr ^ 32'h1013);
        end
      end
    end
  end

  // ---------------- monitor
  bit          prev_stb = 0;
  bit          stb;
  bit          model_last = 1;
  bit          rsp;
  int          stb_len = 0;
  int          w_exp;
  logic [1:0]  req_prev = '0;
  logic [1:0]  stb_op;
  logic [31:0] stb_addr, stb_wdata, rdt, o_rsp, o_rdt;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb = 0; stb_len = 0; model_last = 1; req_prev = '0;
    end else begin
      if (!skip_mon) begin
        stb = bus.mem_read | bus.mem_write;
        if (stb) begin
          stb_len++;
          chk("rw_exclusive", bus.mem_read & bus.mem_write, 0);
          if (!prev_stb) begin
            chk("grant_req", |req_prev, 1);
`ifdef ARB_RR_EN
            w_exp = (req_prev == 2'b11) ? int'(!model_last) : int'(req_prev[1]);
`else
            w_exp = (req_prev == 2'b11) ? 0 : int'(req_prev[1]);
`endif
            model_last = w_exp[0];
            chk("grant_port", bus.mem_addr[13], w_exp);
            chk("grant_owner", bus.owner, w_exp);
            chk("grant_busy", bus.busy, 1);
            if (chk_lat) chk("grant_latency", cyc, issue_cyc[w_exp] + 1);
            if (q_size(w_exp) == 0) begin
              checks++; errors++;
              $display("FAIL grant_unexpected: got grant at addr %h, expected no pending request", bus.mem_addr);
            end else begin
              me = q_front(w_exp);
              chk("mem_op_write", bus.mem_write, me.wr);
              chk("mem_addr", bus.mem_addr, me.addr);
              if (me.wr) chk("mem_wdata", bus.mem_wdata, me.wdata);
            end
            stb_addr  = bus.mem_addr;
            stb_wdata = bus.mem_wdata;
            stb_op    = {bus.mem_read, bus.mem_write};
          end else begin
            chk("hold_addr", bus.mem_addr, stb_addr);
            chk("hold_wdata", bus.mem_wdata, stb_wdata);
            chk("hold_op", {bus.mem_read, bus.mem_write}, stb_op);
          end
        end
        for (int p = 0; p < 2; p++) begin
          rsp = (p == 0) ? bus.r0_resp : bus.r1_resp;
          if (rsp) begin
            rdt   = (p == 0) ? bus.r0_rdata : bus.r1_rdata;
            o_rsp = (p == 0) ? bus.r1_resp : bus.r0_resp;
            o_rdt = (p == 0) ? bus.r1_rdata : bus.r0_rdata;
            if (q_size(p) == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp port%0d: got resp=1 rdata=%h, expected no response", p, rdt);
            end else begin
              me = q_pop(p);
              chk("resp_rdata", rdt, me.rdata);
              chk("other_resp", o_rsp, 0);
              chk("other_rdata", o_rdt, 0);
              chk("resp_cycle", stb_len, me.hang ? TMO + 1 : cur_delay);
            end
          end
        end
        if (!stb) stb_len = 0;
        prev_stb = stb;
      end
      req_prev = {bus.r1_read | bus.r1_write, bus.r0_read | bus.r0_write};
    end
  end

  // ---------------- requesters
  task automatic drive(input int p, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.r0_read = rd; bus.r0_write = wr; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_read = rd; bus.r1_write = wr; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  task automatic idle(input int p, input int n);
    drive(p, 0, 0, '0, '0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the response, request still asserted.
  task automatic issue(input int p, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit mut);
    exp_t e;
    bit   got;
    got     = 0;
    e.wr    = wr;
    e.hang  = a[7];
    e.addr  = a;
    e.wdata = d;
    if (e.hang) e.rdata = ERR;
    else if (wr) begin
      ref_mem[a] = d;
      e.rdata    = ~d;
    end else e.rdata = ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h1013);
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    issue_cyc[p] = cyc;
    drive(p, rd, wr, a, d);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (((p == 0) ? bus.r0_resp : bus.r1_resp) == 1'b1) begin
        got = 1;
        break;
      end
      if (mut && k == 1) drive(p, rd, wr, a ^ 32'h44, ~d);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_wait port%0d: got no response, expected one within 400 cycles", p);
      if (p == 0) q0.delete(); else q1.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic btb(input int p, input int n);
    for (int i = 0; i < n; i++)
      issue(p, p == 0, p == 1, ((p == 0) ? 32'h1040 : 32'h2040) + 32'(i * 4), $urandom, 0);
    idle(p, 1);
  endtask

  task automatic rand_port(input int p, input int n);
    int  r;
    int  gap;
    bit  hang;
    for (int i = 0; i < n; i++) begin
      r    = $urandom_range(0, 99);
      hang = ($urandom_range(0, 99) < 8);
      issue(p, r < 55, r >= 45, raddr(p, hang), $urandom, 0);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(p, gap);
    end
    idle(p, 1);
  endtask

  // ---------------- main sequence
  initial begin
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_r0_resp", bus.r0_resp, 0);
    chk("rst_r1_resp", bus.r1_resp, 0);
    chk("rst_r0_rdata", bus.r0_rdata, 0);
    chk("rst_r1_rdata", bus.r1_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed: single read, write latch with input churn, read-back, read+write
    chk_lat = 1;
    force_delay = 3;
    issue(0, 1, 0, 32'h1000, 32'h0, 0);
    idle(0, 2);
    force_delay = 5;
    issue(1, 0, 1, 32'h2000, 32'hCAFE_F00D, 1);
    idle(1, 2);
    force_delay = 2;
    issue(1, 1, 0, 32'h2000, 32'h0, 0);
    idle(1, 2);
    issue(0, 1, 1, 32'h1004, 32'h5555_AAAA, 0);
    idle(0, 2);
    chk_lat = 0;
    force_delay = 0;

    // both ports re-requesting back-to-back
    fork
      btb(0, 4);
      btb(1, 4);
    join
    idle(0, 2);

    // watchdog expiry, then a stray mem_resp while idle
    chk("tmo_err_clear", bus.timeout_err, 0);
    issue(0, 1, 0, 32'h1080, 32'h0, 0);
    drive(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("tmo_err_set", bus.timeout_err, 1);
    late_pulse = 1;
    repeat (2) @(negedge clk);
    chk("late_r0_resp", bus.r0_resp, 0);
    chk("late_r1_resp", bus.r1_resp, 0);
    chk("late_busy", bus.busy, 0);
    @(negedge clk);
    chk("late_busy_after", bus.busy, 0);
    chk("tmo_err_sticky", bus.timeout_err, 1);
    @(posedge clk); #1;

    // randomized traffic on both ports
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    repeat (3) @(posedge clk); #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("tmo_err_end", bus.timeout_err, 1);

    // asynchronous reset while port 1 owns a write
    skip_mon = 1;
    force_delay = 30;
    drive(1, 0, 1, 32'h2010, 32'h1234_5678);
    repeat (3) @(negedge clk);
    chk("pre_rst_write", bus.mem_write, 1);
    chk("pre_rst_owner", bus.owner, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_write", bus.mem_write, 0);
    chk("arst_mem_read", bus.mem_read, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_owner", bus.owner, 0);
    chk("arst_r1_resp", bus.r1_resp, 0);
    chk("arst_timeout_err", bus.timeout_err, 0);
    drive(1, 0, 0, '0, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
